// File: rtl/data_mem_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : data_mem_ctrl
// Description : Word-organised data memory behind a request/acknowledge
//               handshake. Supports byte/halfword/word loads and stores with
//               sign or zero extension, a configurable number of wait cycles
//               before the access, and alignment/range error reporting.
// Ports       : Clock    - rising-edge clock
//               Resetn   - asynchronous active-low reset
//               Req      - request, sampled while Ready=1
//               Write    - 1 = store, 0 = load
//               Size     - 00 byte, 01 halfword, 10 word, 11 reserved
//               Unsigned - loads: 1 = zero-extend, 0 = sign-extend
//               Addr     - byte address, little-endian
//               WData    - store data (low bits used for byte/halfword)
//               Ready    - idle, a request is accepted
//               Ack      - one-cycle completion pulse
//               RData    - load result, held until the next Ack
//               Err      - error flag of the completing access
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module data_mem_ctrl #(
   parameter int DEPTH_LOG2  = 5,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Req,
   input  logic        Write,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   input  logic [31:0] Addr,
   input  logic [31:0] WData,
   output logic        Ready,
   output logic        Ack,
   output logic [31:0] RData,
   output logic        Err
);

   localparam int         c_depth     = 1 << DEPTH_LOG2;
   localparam logic [3:0] c_wait      = 4'(WAIT_CYCLES);
   localparam logic [1:0] c_size_byte = 2'b00;
   localparam logic [1:0] c_size_half = 2'b01;
   localparam logic [1:0] c_size_word = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_nxt;
   logic                  w_accept;
   logic                  w_access;

   // Request fields captured at acceptance; inputs may change afterwards.
   logic                  r_write;
   logic [1:0]            r_size;
   logic                  r_unsigned;
   logic [31:0]           r_addr;
   logic [31:0]           r_wdata;

   // Each word is stored XOR-ed with its power-up value (index squared).
   // Two-state storage starts at zero, so the array reads back as the
   // squares table from time zero with no initialisation sequence, and a
   // reset leaves the contents untouched.
   bit   [31:0]           r_delta [c_depth];
   logic [31:0]           w_pattern [c_depth];

   logic [DEPTH_LOG2-1:0] w_idx;
   logic [4:0]            w_shift;
   logic [31:0]           w_word;
   logic [15:0]           w_lane;
   logic [31:0]           w_mask;
   logic [31:0]           w_new;
   logic [31:0]           w_load;
   logic                  w_err;

   for (genvar gi = 0; gi < c_depth; gi++) begin : g_pattern
      assign w_pattern[gi] = 32'(gi * gi);
   end

   //---------------------------------------------------------------------------
   // Control FSM
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_access    = 1'b0;
      Ready       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            Ready = 1'b1;
            if (Req) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = c_wait;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (r_cnt == 4'd0) begin
               w_access    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_write    <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         Ack        <= 1'b0;
         RData      <= 32'd0;
         Err        <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         Ack     <= w_access;
         if (w_accept) begin
            r_write    <= Write;
            r_size     <= Size;
            r_unsigned <= Unsigned;
            r_addr     <= Addr;
            r_wdata    <= WData;
         end
         if (w_access) begin
            Err   <= w_err;
            RData <= (w_err || r_write) ? 32'd0 : w_load;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Datapath: lane select, error check, store merge
   //---------------------------------------------------------------------------
   assign w_idx   = r_addr[DEPTH_LOG2+1:2];
   assign w_shift = {r_addr[1:0], 3'b000};
   assign w_word  = r_delta[w_idx] ^ w_pattern[w_idx];
   assign w_lane  = 16'(w_word >> w_shift);

   always_comb begin
      w_err  = (r_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
      w_mask = 32'hFFFF_FFFF;
      w_load = w_word;
      case (r_size)
         c_size_byte: begin
            w_mask = 32'h0000_00FF << w_shift;
            w_load = r_unsigned ? {24'd0, w_lane[7:0]}
                                : {{24{w_lane[7]}}, w_lane[7:0]};
         end
         c_size_half: begin
            // A misaligned halfword errors, so w_shift is 0 or 16 when used.
            w_err  = w_err | r_addr[0];
            w_mask = 32'h0000_FFFF << w_shift;
            w_load = r_unsigned ? {16'd0, w_lane}
                                : {{16{w_lane[15]}}, w_lane};
         end
         c_size_word: begin
            w_err = w_err | (r_addr[1:0] != 2'b00);
         end
         default: begin
            w_err = 1'b1;
         end
      endcase
   end

   assign w_new = (w_word & ~w_mask) | ((r_wdata << w_shift) & w_mask);

   // The FSM is forced to IDLE while Resetn is low, so an aborted access
   // never reaches this write.
   always_ff @(posedge Clock) begin
      if (w_access && r_write && !w_err) begin
         r_delta[w_idx] <= w_new ^ w_pattern[w_idx];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl. Two instances
//               (WAIT_CYCLES 0 and 3) share the request inputs; sel chooses
//               which one sees Req and whose outputs are observed. Expected
//               results come from a byte-addressed reference memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_data_mem_ctrl;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        Req;
   logic        Write;
   logic [1:0]  Size;
   logic        Unsigned;
   logic [31:0] Addr;
   logic [31:0] WData;
   logic        sel;

   logic        rdy0, ack0, err0, rdy3, ack3, err3;
   logic [31:0] rd0, rd3;
   logic        Ready, Ack, Err;
   logic [31:0] RData;

   int n_tests = 0;
   int n_fail  = 0;

   // reference memory: [instance][byte address]
   logic [7:0] mem [2][128];

   always #5 Clock = ~Clock;

   data_mem_ctrl #(.DEPTH_LOG2(5), .WAIT_CYCLES(0)) dut0 (
      .Clock(Clock), .Resetn(Resetn), .Req(Req && !sel), .Write(Write),
      .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .WData(WData),
      .Ready(rdy0), .Ack(ack0), .RData(rd0), .Err(err0)
   );

   data_mem_ctrl #(.DEPTH_LOG2(5), .WAIT_CYCLES(3)) dut3 (
      .Clock(Clock), .Resetn(Resetn), .Req(Req && sel), .Write(Write),
      .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .WData(WData),
      .Ready(rdy3), .Ack(ack3), .RData(rd3), .Err(err3)
   );

   assign Ready = sel ? rdy3 : rdy0;
   assign Ack   = sel ? ack3 : ack0;
   assign RData = sel ? rd3  : rd0;
   assign Err   = sel ? err3 : err0;

   // Reference behaviour: byte array, little-endian, aligned accesses only.
   function automatic void model(input int s, input logic w, input logic [1:0] sz,
                                 input logic u, input logic [31:0] a,
                                 input logic [31:0] d,
                                 output logic [31:0] rd, output logic er);
      int nb;
      int base;
      rd = 32'd0;
      er = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
           (sz == 2'd2 && a % 4 != 0) || (a >= 32'd128);
      if (er) return;
      nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      base = int'(a[6:0]);
      if (w) begin
         for (int k = 0; k < nb; k++) mem[s][base + k] = d[8*k +: 8];
      end else begin
         for (int k = 0; k < nb; k++) rd[8*k +: 8] = mem[s][base + k];
         if (!u && nb < 4 && rd[8*nb-1])
            for (int k = nb; k < 4; k++) rd[8*k +: 8] = 8'hFF;
      end
   endfunction

   // One handshake: waits for Ready, presents the request for one edge,
   // scrambles the inputs, then counts edges until Ack.
   task automatic xact(input logic s, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
      int guard;
      @(negedge Clock);
      sel   = s;
      guard = 0;
      while (!Ready && guard < 50) begin
         @(negedge Clock);
         guard++;
      end
      Req = 1'b1; Write = w; Size = sz; Unsigned = u; Addr = a; WData = d;
      @(posedge Clock);
      #1;
      Req      = 1'b0;
      Write    = 1'($urandom);
      Size     = 2'($urandom);
      Unsigned = 1'($urandom);
      Addr     = $urandom;
      WData    = $urandom;
      lat = 0;
      while (!Ack && lat < 40) begin
         @(posedge Clock);
         #1;
         lat++;
      end
      rd = RData;
      er = Err;
   endtask

   task automatic op(input logic s, input logic w, input logic [1:0] sz,
                     input logic u, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat,
                     output logic [31:0] erd, output logic eer);
      xact(s, w, sz, u, a, d, rd, er, lat);
      model(int'(s), w, sz, u, a, d, erd, eer);
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      #12;
      n_tests++; if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b%b want 11", rdy0, rdy3); end
      n_tests++; if (ack0 !== 1'b0 || ack3 !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b%b want 00", ack0, ack3); end
      n_tests++; if (rd0 !== 32'd0 || rd3 !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h %h want 0", rd0, rd3); end
      n_tests++; if (err0 !== 1'b0 || err3 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b want 00", err0, err3); end
      @(negedge Clock);
      Resetn = 1'b1;
      @(posedge Clock);
      #1;
      n_tests++; if (rdy0 !== 1'b1 || ack0 !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got rdy=%b ack=%b want 1 0", rdy0, ack0); end
   endtask

   task automatic test_word_read();
      logic [31:0] rd, erd; logic er, eer; int lat;
      op(1'b0, 1'b0, 2'd2, 1'b0, 32'h0C, 32'd0, rd, er, lat, erd, eer);
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL w0_latency got %0d want 1", lat); end
      n_tests++; if (rd !== 32'h0000_0009 || er !== 1'b0) begin n_fail++; $display("FAIL word_read_0C got %h err=%b want 00000009 err=0", rd, er); end
   endtask

   task automatic test_byte_half();
      logic [31:0] rd, erd; logic er, eer; int lat;
      op(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_56AB, rd, er, lat, erd, eer);
      n_tests++; if (rd !== 32'd0 || er !== 1'b0) begin n_fail++; $display("FAIL byte_store got %h err=%b want 0 err=0", rd, er); end
      op(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat, erd, eer);
      n_tests++; if (rd !== 32'h0000_AB10) begin n_fail++; $display("FAIL byte_merge got %h want 0000ab10", rd); end
      op(1'b0, 1'b0, 2'd0, 1'b0, 32'h11, 32'd0, rd, er, lat, erd, eer);
      n_tests++; if (rd !== 32'hFFFF_FFAB) begin n_fail++; $display("FAIL byte_signed got %h want ffffffab", rd); end
      op(1'b0, 1'b0, 2'd0, 1'b1, 32'h11, 32'd0, rd, er, lat, erd, eer);
      n_tests++; if (rd !== 32'h0000_00AB) begin n_fail++; $display("FAIL byte_unsigned got %h want 000000ab", rd); end
      op(1'b0, 1'b1, 2'd1, 1'b0, 32'h1A, 32'hFFFF_8001, rd, er, lat, erd, eer);
      op(1'b0, 1'b0, 2'd2, 1'b0, 32'h18, 32'd0, rd, er, lat, erd, eer);
      n_tests++; if (rd !== 32'h8001_0024) begin n_fail++; $display("FAIL half_merge got %h want 80010024", rd); end
      op(1'b0, 1'b0, 2'd1, 1'b0, 32'h1A, 32'd0, rd, er, lat, erd, eer);
      n_tests++; if (rd !== 32'hFFFF_8001) begin n_fail++; $display("FAIL half_signed got %h want ffff8001", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd, erd; logic er, eer; int lat;
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h06, 32'hDEAD_BEEF, rd, er, lat, erd, eer);
      n_tests++; if (er !== 1'b1 || rd !== 32'd0 || lat != 1) begin n_fail++; $display("FAIL err_misaligned_word got err=%b rd=%h lat=%0d want 1 0 1", er, rd, lat); end
      op(1'b0, 1'b0, 2'd2, 1'b0, 32'h04, 32'd0, rd, er, lat, erd, eer);
      n_tests++; if (rd !== 32'h0000_0001 || er !== 1'b0) begin n_fail++; $display("FAIL err_no_write got %h err=%b want 00000001 0", rd, er); end
      op(1'b0, 1'b0, 2'd2, 1'b0, 32'h80, 32'd0, rd, er, lat, erd, eer);
      n_tests++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err_range got err=%b rd=%h want 1 0", er, rd); end
      op(1'b0, 1'b0, 2'd3, 1'b0, 32'h00, 32'd0, rd, er, lat, erd, eer);
      n_tests++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err_size11 got err=%b rd=%h want 1 0", er, rd); end
      op(1'b0, 1'b0, 2'd1, 1'b0, 32'h03, 32'd0, rd, er, lat, erd, eer);
      n_tests++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err_half_odd got err=%b rd=%h want 1 0", er, rd); end
   endtask

   task automatic test_wait3();
      logic [31:0] rd, erd; logic er, eer; int lat;
      int extra;
      time t_prev, t_now;
      @(negedge Clock);
      sel = 1'b1;
      Req = 1'b1; Write = 1'b0; Size = 2'd2; Unsigned = 1'b0; Addr = 32'h0C; WData = 32'd0;
      @(posedge Clock);
      // Req stays high through BUSY; only one Ack may appear.
      for (int e = 0; e <= 4; e++) begin
         if (e > 0) begin
            @(posedge Clock);
         end
         #1;
         n_tests++;
         if (Ready !== (e == 4) || Ack !== (e == 4)) begin
            n_fail++;
            $display("FAIL w3_busy_edge%0d got rdy=%b ack=%b want %b %b", e, Ready, Ack, e == 4, e == 4);
         end
      end
      Req = 1'b0;
      n_tests++; if (RData !== 32'h0000_0009) begin n_fail++; $display("FAIL w3_rdata got %h want 00000009", RData); end
      extra = 0;
      repeat (8) begin
         @(posedge Clock);
         #1;
         if (Ack) extra++;
      end
      n_tests++; if (extra != 0) begin n_fail++; $display("FAIL w3_extra_ack got %0d want 0", extra); end
      // back-to-back: Acks five cycles apart
      t_prev = 0;
      for (int i = 0; i < 3; i++) begin
         op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0C, 32'd0, rd, er, lat, erd, eer);
         t_now = $time;
         n_tests++; if (lat != 4) begin n_fail++; $display("FAIL w3_latency got %0d want 4", lat); end
         if (i > 0) begin
            n_tests++;
            if (t_now - t_prev != 50) begin n_fail++; $display("FAIL w3_b2b_spacing got %0t want 50", t_now - t_prev); end
         end
         t_prev = t_now;
      end
   endtask

   task automatic test_reset_busy();
      logic [31:0] rd, erd; logic er, eer; int lat;
      int acks;
      @(negedge Clock);
      sel = 1'b1;
      Req = 1'b1; Write = 1'b1; Size = 2'd2; Unsigned = 1'b0; Addr = 32'h20; WData = 32'h1234_5678;
      @(posedge Clock);
      #1;
      Req = 1'b0;
      @(posedge Clock);
      #1;
      acks   = 0;
      Resetn = 1'b0;
      #1;
      n_tests++; if (Ready !== 1'b1 || Ack !== 1'b0 || RData !== 32'd0 || Err !== 1'b0) begin n_fail++; $display("FAIL rst_busy_async got rdy=%b ack=%b rd=%h err=%b want 1 0 0 0", Ready, Ack, RData, Err); end
      @(negedge Clock);
      Resetn = 1'b1;
      repeat (6) begin
         @(posedge Clock);
         #1;
         if (Ack) acks++;
      end
      n_tests++; if (acks != 0 || Ready !== 1'b1) begin n_fail++; $display("FAIL rst_busy_no_ack got acks=%0d rdy=%b want 0 1", acks, Ready); end
      op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, rd, er, lat, erd, eer);
      n_tests++; if (rd !== 32'h0000_0040 || er !== 1'b0) begin n_fail++; $display("FAIL rst_busy_mem got %h err=%b want 00000040 0", rd, er); end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, a, d; logic er, eer, s, w, u; logic [1:0] sz; int lat;
      for (int i = 0; i < 300; i++) begin
         s  = 1'($urandom);
         w  = 1'($urandom);
         sz = 2'($urandom);
         u  = 1'($urandom);
         d  = $urandom;
         a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
         // bias toward aligned addresses so most accesses succeed
         if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd2) ? 32'd3 : (sz == 2'd1) ? 32'd1 : 32'd0);
         op(s, w, sz, u, a, d, rd, er, lat, erd, eer);
         n_tests++;
         if (rd !== erd || er !== eer || lat != (s ? 4 : 1)) begin
            n_fail++;
            $display("FAIL rand%0d s=%b w=%b sz=%0d u=%b a=%h got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                     i, s, w, sz, u, a, rd, er, lat, erd, eer, s ? 4 : 1);
         end
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 32; i++)
            for (int k = 0; k < 4; k++)
               mem[s][4*i + k] = 8'((i * i) >> (8 * k));
      Req = 1'b0; Write = 1'b0; Size = 2'd0; Unsigned = 1'b0;
      Addr = 32'd0; WData = 32'd0; sel = 1'b0;
      test_reset();
      test_word_read();
      test_byte_half();
      test_errors();
      test_wait3();
      test_reset_busy();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data memory with a request/acknowledge handshake, configurable access latency, and byte/halfword/word accesses with sign or zero extension. It sits on the CPU data path behind the load/store unit. It adds alignment and range error reporting, and leaves a fixed 32-bit word array.

Parameters:
DEPTH_LOG2, 5, log2 of number of 32-bit words (default 32 words, byte addresses 0x00–0x7F).
WAIT_CYCLES, 0, extra wait cycles before the access edge (legal 0–15).

Ports:
Clock  in  1  rising-edge clock.
Resetn  in  1  asynchronous, active-low reset.
Req  in  1  request; sampled only while Ready=1.
Write  in  1  1 = store, 0 = load.
Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error).
Unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
Addr  in  32  byte address, little-endian.
WData  in  32  store data; byte uses [7:0], halfword uses [15:0].
Ready  out  1  high in IDLE; a request is accepted.
Ack  out  1  one-cycle completion pulse.
RData  out  32  load result; valid when Ack=1, held until the next Ack.
Err  out  1  error flag for the completing access; valid with Ack, held until the next Ack.

Behaviour:
- Reset (Resetn low, asynchronous): state=IDLE, Ready=1, Ack=0, RData=0, Err=0, wait counter=0. Memory array is not cleared.
- Memory init at time zero: word i = i*i for all i < 2^DEPTH_LOG2.
- Word index = Addr[DEPTH_LOG2+1:2]. Lane = Addr[1:0].
- FSM states: IDLE, BUSY.
  - IDLE: Ready=1. On an edge E0 with Req=1, latch Write/Size/Unsigned/Addr/WData, load counter=WAIT_CYCLES, go to BUSY.
  - BUSY: Ready=0. Req is ignored. Counter decrements each edge. At the edge where the counter is 0 (edge E0+WAIT_CYCLES+1), perform the access, register Ack=1, RData and Err, and return to IDLE.
- Ack is high for exactly one cycle. Ack is cleared at the next edge unless a new access completes there.
- Latency: Ack rises WAIT_CYCLES+1 edges after the acceptance edge. Maximum throughput is one access per WAIT_CYCLES+2 cycles: a new request can be accepted at the edge that ends the Ack cycle.
- Error check uses latched fields and is evaluated at the access edge. Err=1 if any of:
  - Size=11;
  - halfword with Addr[0]=1;
  - word with Addr[1:0]≠0;
  - Addr[31:DEPTH_LOG2+2]≠0.
- On error: no memory write, RData=0, Err=1, Ack still asserted.
- Store:
  - byte writes WData[7:0] into lane Addr[1:0];
  - halfword writes WData[15:0] into bytes Addr[1]*2 and Addr[1]*2+1;
  - word writes all 32 bits;
  - other bytes of the word are unchanged.
- On a store, RData=0 and Err=0 (if no error).
- Load: extract the lane and extend to 32 bits per Unsigned. A word load ignores Unsigned.
- Input signals need not be held after acceptance.
- Reset during BUSY aborts the access: no write, no Ack, memory contents preserved.

Test Plan:
1. After reset, word read of Addr=0x0C, WAIT_CYCLES=0 → Ready=1 out of reset; Ack exactly 1 edge after acceptance; RData=0x00000009, Err=0.
2. Byte write 0xAB to 0x11, then word read of 0x10 → 0x0000AB10. Signed byte read of 0x11 → 0xFFFFFFAB. Unsigned byte read → 0x000000AB.
3. Halfword write 0x8001 to 0x1A, then word read of 0x18 → 0x80010024. Signed halfword read of 0x1A → 0xFFFF8001.
4. Error cases:
   - word write 0xDEADBEEF to 0x06 → Ack with Err=1, RData=0; word read of 0x04 still returns 0x00000001;
   - Addr=0x80 → Err=1;
   - Size=11 → Err=1;
   - halfword read of 0x03 → Err=1.
5. WAIT_CYCLES=3: request accepted → Ready low for 4 cycles; Ack 4 edges after acceptance; Req held high during BUSY produces no extra Ack. Back-to-back requests complete one per 5 cycles.
6. Resetn pulsed low while BUSY on a word write of 0x12345678 to 0x20 → no Ack; after release Ready=1, RData=0; word read of 0x20 returns 0x00000040.
